// File: rtl/axis_pkg.sv
// Shared AXI4-Stream definitions: default widths, keep-width helper and the
// arbiter FSM state encoding.
package axis_pkg;

    localparam int AXIS_DATA_WIDTH_DEF  = 512;
    localparam int AXIS_TUSER_WIDTH_DEF = 256;

    // One tkeep bit per data byte.
    function automatic int keep_width(input int data_width);
        return data_width / 8;
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin first-valid finder. Starting just after last_i
// and wrapping modulo NUM_PORTS, returns the first asserted request.
module rr_pick #(
    parameter int NUM_PORTS = 2,
    parameter int IDX_WIDTH = 3
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IDX_WIDTH-1:0] last_i,
    output logic [IDX_WIDTH-1:0] idx_o,
    output logic                 found_o
);

    // Scan candidates last+1, last+2, ... and keep the first one requesting.
    always_comb begin
        int  cand;
        logic found;
        // NOTE: every output gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = (int'(last_i) + k) % NUM_PORTS;
            // Compare against a constant loop index so the request select
            // never uses a variable, oversized index.
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (!found && (j == cand) && req_i[j]) begin
                    found = 1'b1;
                    idx_o = IDX_WIDTH'(j);
                end
            end
        end
        found_o = found;
    end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_PORTS AXI4-Stream sources
// into one registered master stream. A grant is held from the first beat to
// tlast, so packets never interleave. A reset mid-packet abandons the packet:
// downstream sees it truncated with no tlast.
module axis_pkt_arbiter
    import axis_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH  = AXIS_DATA_WIDTH_DEF,
    parameter int AXIS_TUSER_WIDTH = AXIS_TUSER_WIDTH_DEF,
    parameter int NUM_PORTS        = 2,
    parameter int PORT_IDX_WIDTH   = 3
) (
    input  logic                                              axis_aclk,
    input  logic                                              axis_reset,

    input  logic [NUM_PORTS*AXIS_DATA_WIDTH-1:0]              s_axis_tdata,
    input  logic [NUM_PORTS*keep_width(AXIS_DATA_WIDTH)-1:0]  s_axis_tkeep,
    input  logic [NUM_PORTS*AXIS_TUSER_WIDTH-1:0]             s_axis_tuser,
    input  logic [NUM_PORTS-1:0]                              s_axis_tvalid,
    output logic [NUM_PORTS-1:0]                              s_axis_tready,
    input  logic [NUM_PORTS-1:0]                              s_axis_tlast,

    output logic [AXIS_DATA_WIDTH-1:0]                        m_axis_tdata,
    output logic [keep_width(AXIS_DATA_WIDTH)-1:0]            m_axis_tkeep,
    output logic [AXIS_TUSER_WIDTH-1:0]                       m_axis_tuser,
    output logic                                              m_axis_tvalid,
    input  logic                                              m_axis_tready,
    output logic                                              m_axis_tlast,

    output logic [PORT_IDX_WIDTH-1:0]                         grant_idx,
    output logic                                              busy
);

    localparam int KEEP_W = keep_width(AXIS_DATA_WIDTH);

    arb_state_e                  state_q, state_d;
    logic [PORT_IDX_WIDTH-1:0]   grant_q, grant_d;
    logic [PORT_IDX_WIDTH-1:0]   last_grant_q, last_grant_d;

    logic [AXIS_DATA_WIDTH-1:0]  m_tdata_q, m_tdata_d;
    logic [KEEP_W-1:0]           m_tkeep_q, m_tkeep_d;
    logic [AXIS_TUSER_WIDTH-1:0] m_tuser_q, m_tuser_d;
    logic                        m_tlast_q, m_tlast_d;
    logic                        m_tvalid_q, m_tvalid_d;

    // Signals of the currently granted port.
    logic [AXIS_DATA_WIDTH-1:0]  sel_tdata;
    logic [KEEP_W-1:0]           sel_tkeep;
    logic [AXIS_TUSER_WIDTH-1:0] sel_tuser;
    logic                        sel_tvalid;
    logic                        sel_tlast;

    logic [PORT_IDX_WIDTH-1:0]   pick_idx;
    logic                        pick_found;
    logic                        out_ready;

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_WIDTH (PORT_IDX_WIDTH)
    ) u_rr_pick (
        .req_i   (s_axis_tvalid),
        .last_i  (last_grant_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    // Mux the granted slave's beat onto the sel_* signals.
    always_comb begin
        sel_tdata  = '0;
        sel_tkeep  = '0;
        sel_tuser  = '0;
        sel_tvalid = 1'b0;
        sel_tlast  = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_q == PORT_IDX_WIDTH'(i)) begin
                sel_tdata  = s_axis_tdata[i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
                sel_tkeep  = s_axis_tkeep[i*KEEP_W +: KEEP_W];
                sel_tuser  = s_axis_tuser[i*AXIS_TUSER_WIDTH +: AXIS_TUSER_WIDTH];
                sel_tvalid = s_axis_tvalid[i];
                sel_tlast  = s_axis_tlast[i];
            end
        end
    end

    // The output slice can take a beat when empty or draining this cycle.
    assign out_ready = !m_tvalid_q || m_axis_tready;

    // Next-state, slave readies and output-register load/drain.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        m_tdata_d     = m_tdata_q;
        m_tkeep_d     = m_tkeep_q;
        m_tuser_d     = m_tuser_q;
        m_tlast_d     = m_tlast_q;
        m_tvalid_d    = m_tvalid_q;
        s_axis_tready = '0;

        // Drain; overridden below when a new beat loads in the same cycle.
        if (m_tvalid_q && m_axis_tready) begin
            m_tvalid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (grant_q == PORT_IDX_WIDTH'(i)) begin
                        s_axis_tready[i] = out_ready;
                    end
                end
                if (sel_tvalid && out_ready) begin
                    m_tdata_d  = sel_tdata;
                    m_tkeep_d  = sel_tkeep;
                    m_tuser_d  = sel_tuser;
                    m_tlast_d  = sel_tlast;
                    m_tvalid_d = 1'b1;
                    if (sel_tlast) begin
                        last_grant_d = grant_q;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, grant history and output register, with synchronous reset.
    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            // NOTE: non-blocking assignments here so every flop samples the
            // pre-edge values, independent of statement order.
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= PORT_IDX_WIDTH'(NUM_PORTS - 1);
            m_tvalid_q   <= 1'b0;
            // NOTE: the datapath registers are reset too because the output
            // must read all-zero after reset; wide data flops normally skip it.
            m_tdata_q    <= '0;
            m_tkeep_q    <= '0;
            m_tuser_q    <= '0;
            m_tlast_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            m_tvalid_q   <= m_tvalid_d;
            m_tdata_q    <= m_tdata_d;
            m_tkeep_q    <= m_tkeep_d;
            m_tuser_q    <= m_tuser_d;
            m_tlast_q    <= m_tlast_d;
        end
    end

    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tkeep  = m_tkeep_q;
    assign m_axis_tuser  = m_tuser_q;
    assign m_axis_tlast  = m_tlast_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign grant_idx     = grant_q;
    assign busy          = (state_q == BUSY);

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Directed testbench for axis_pkt_arbiter: latency, round-robin order,
// packet atomicity, backpressure stability and mid-packet reset.
module tb_axis_pkt_arbiter;

    localparam int DW = 512;
    localparam int UW = 256;
    localparam int KW = DW / 8;
    localparam int NP = 2;
    localparam int IW = 3;

    logic               axis_aclk = 1'b0;
    logic               axis_reset;
    logic [NP*DW-1:0]   s_axis_tdata;
    logic [NP*KW-1:0]   s_axis_tkeep;
    logic [NP*UW-1:0]   s_axis_tuser;
    logic [NP-1:0]      s_axis_tvalid;
    logic [NP-1:0]      s_axis_tready;
    logic [NP-1:0]      s_axis_tlast;
    logic [DW-1:0]      m_axis_tdata;
    logic [KW-1:0]      m_axis_tkeep;
    logic [UW-1:0]      m_axis_tuser;
    logic               m_axis_tvalid;
    logic               m_axis_tready;
    logic               m_axis_tlast;
    logic [IW-1:0]      grant_idx;
    logic               busy;

    axis_pkt_arbiter #(
        .AXIS_DATA_WIDTH  (DW),
        .AXIS_TUSER_WIDTH (UW),
        .NUM_PORTS        (NP),
        .PORT_IDX_WIDTH   (IW)
    ) dut (
        .axis_aclk     (axis_aclk),
        .axis_reset    (axis_reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .grant_idx     (grant_idx),
        .busy          (busy)
    );

    always #5 axis_aclk = ~axis_aclk;

    int n_checks = 0;
    int n_fails  = 0;
    logic rand_en = 1'b0;

    logic [63:0] out_q[$];
    int          out_cyc_q[$];
    logic [63:0] exp_q[$];
    int          cyc = 0;
    logic        stall_prev = 1'b0;
    logic [63:0] stall_word = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Compact signature of one beat: data, keep byte, user half-word, last.
    function automatic logic [63:0] beat_word(input logic [31:0] d, input logic l);
        logic [7:0]  k;
        logic [15:0] u;
        k = d[7:0] ^ 8'h5A;
        u = 16'(d * 32'd3);
        return {d, k, u, 7'b0, l};
    endfunction

    function automatic logic [63:0] m_word();
        return {m_axis_tdata[31:0], m_axis_tkeep[7:0], m_axis_tuser[15:0], 7'b0, m_axis_tlast};
    endfunction

    task automatic set_port(input int p, input logic v, input logic [31:0] d, input logic l);
        logic [7:0]  k;
        logic [15:0] u;
        k = d[7:0] ^ 8'h5A;
        u = 16'(d * 32'd3);
        s_axis_tvalid[p] = v;
        s_axis_tlast[p]  = l;
        s_axis_tdata[p*DW +: DW] = DW'(d);
        s_axis_tkeep[p*KW +: KW] = {{(KW-8){1'b1}}, k};
        s_axis_tuser[p*UW +: UW] = UW'(u);
    endtask

    task automatic tick();
        @(posedge axis_aclk);
        #2;
    endtask

    // Sends one packet on port p; called 2 time units after a rising edge.
    task automatic send_pkt(input int p, input int n, input logic [31:0] base);
        logic acc;
        int   guard;
        for (int b = 0; b < n; b++) begin
            set_port(p, 1'b1, base + 32'(b), (b == n - 1));
            acc   = 1'b0;
            guard = 0;
            while (!acc && guard < 2000) begin
                #2;
                acc = s_axis_tready[p];
                @(posedge axis_aclk);
                #2;
                guard++;
            end
            if (!acc) check("tx_timeout", 64'(acc), 64'd1);
        end
        set_port(p, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic expect_pkt(input logic [31:0] base, input int n);
        for (int b = 0; b < n; b++) exp_q.push_back(beat_word(base + 32'(b), (b == n - 1)));
    endtask

    task automatic compare_out(input string tag);
        check({tag, "_count"}, 64'(out_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            check(tag, out_q[i], exp_q[i]);
        end
        out_q.delete();
        out_cyc_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        axis_reset = 1'b1;
        tick();
        tick();
        axis_reset = 1'b0;
    endtask

    // Downstream ready: constant 1, or a coin toss per cycle when rand_en.
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge axis_aclk);
            #1;
            m_axis_tready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor on the falling edge: collects beats, checks stall
    // stability and that only the granted port is ever ready.
    always @(negedge axis_aclk) begin
        cyc <= cyc + 1;
        if (axis_reset) begin
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", 64'(m_axis_tvalid), 64'd1);
                check("stall_data", m_word(), stall_word);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                out_q.push_back(m_word());
                out_cyc_q.push_back(cyc);
            end
            stall_prev <= m_axis_tvalid && !m_axis_tready;
            stall_word <= m_word();
            for (int i = 0; i < NP; i++) begin
                if (s_axis_tready[i]) begin
                    check("ready_grant", 64'(grant_idx), 64'(i));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        axis_reset    = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tuser  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        do_reset();

        // Reset state.
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tready", 64'(s_axis_tready), 64'd0);
        check("rst_grant",  64'(grant_idx), 64'd0);
        check("rst_busy",   64'(busy), 64'd0);
        check("rst_data",   m_word(), 64'd0);

        // Test 1: 3-beat packet on port 0, cycle-exact latency.
        set_port(0, 1'b1, 32'h11, 1'b0);
        #1;
        check("t1_idle_ready", 64'(s_axis_tready), 64'd0);
        tick();
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_grant", 64'(grant_idx), 64'd0);
        check("t1_no_out_yet", 64'(m_axis_tvalid), 64'd0);
        check("t1_ready", 64'(s_axis_tready), 64'd1);
        tick();
        check("t1_b0_valid", 64'(m_axis_tvalid), 64'd1);
        check("t1_b0", m_word(), beat_word(32'h11, 1'b0));
        set_port(0, 1'b1, 32'h22, 1'b0);
        tick();
        check("t1_b1", m_word(), beat_word(32'h22, 1'b0));
        set_port(0, 1'b1, 32'h33, 1'b1);
        tick();
        check("t1_b2", m_word(), beat_word(32'h33, 1'b1));
        check("t1_busy_fall", 64'(busy), 64'd0);
        set_port(0, 1'b0, 32'd0, 1'b0);
        tick();
        check("t1_drained", 64'(m_axis_tvalid), 64'd0);
        check("t1_grant_hold", 64'(grant_idx), 64'd0);

        // Test 2: both ports continuously offer 2-beat packets.
        do_reset();
        out_q.delete();
        out_cyc_q.delete();
        fork
            begin send_pkt(0, 2, 32'h100); send_pkt(0, 2, 32'h120); end
            begin send_pkt(1, 2, 32'h200); send_pkt(1, 2, 32'h220); end
        join
        repeat (3) tick();
        if (out_cyc_q.size() == 8) begin
            check("t2_in_pkt_gap", 64'(out_cyc_q[1] - out_cyc_q[0]), 64'd1);
            check("t2_gap_a", 64'(out_cyc_q[2] - out_cyc_q[1]), 64'd2);
            check("t2_gap_b", 64'(out_cyc_q[4] - out_cyc_q[3]), 64'd2);
            check("t2_gap_c", 64'(out_cyc_q[6] - out_cyc_q[5]), 64'd2);
        end
        expect_pkt(32'h100, 2);
        expect_pkt(32'h200, 2);
        expect_pkt(32'h120, 2);
        expect_pkt(32'h220, 2);
        compare_out("t2_order");

        // Test 3: port 0 raises tvalid while port 1 is mid-packet.
        fork
            send_pkt(1, 4, 32'h300);
            begin
                tick();
                tick();
                tick();
                set_port(0, 1'b1, 32'h400, 1'b0);
                #2;
                check("t3_p0_blocked", 64'(s_axis_tready[0]), 64'd0);
                check("t3_grant_p1", 64'(grant_idx), 64'd1);
                send_pkt(0, 2, 32'h400);
            end
        join
        repeat (3) tick();
        expect_pkt(32'h300, 4);
        expect_pkt(32'h400, 2);
        compare_out("t3_order");

        // Test 4: 64-beat packet under random downstream backpressure.
        rand_en = 1'b1;
        send_pkt(0, 64, 32'd0);
        rand_en = 1'b0;
        repeat (4) tick();
        expect_pkt(32'd0, 64);
        compare_out("t4_seq");

        // Test 5: reset at beat 2 of a 4-beat packet on port 0.
        set_port(0, 1'b1, 32'h500, 1'b0);
        tick();
        tick();
        set_port(0, 1'b1, 32'h501, 1'b0);
        tick();
        set_port(0, 1'b1, 32'h502, 1'b0);
        axis_reset = 1'b1;
        tick();
        axis_reset = 1'b0;
        check("t5_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("t5_tready", 64'(s_axis_tready), 64'd0);
        check("t5_grant", 64'(grant_idx), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        set_port(0, 1'b0, 32'd0, 1'b0);
        tick();
        check("t5_idle", 64'(busy), 64'd0);
        out_q.delete();
        out_cyc_q.delete();
        fork
            send_pkt(0, 2, 32'h510);
            send_pkt(1, 2, 32'h610);
        join
        repeat (3) tick();
        expect_pkt(32'h510, 2);
        expect_pkt(32'h610, 2);
        compare_out("t5_prio");

        // Test 6: single-beat packets on port 0 against a 128-beat replay
        // on port 1 followed by a single-beat packet.
        fork
            for (int k = 0; k < 4; k++) send_pkt(0, 1, 32'h700 + 32'(k * 16));
            begin send_pkt(1, 128, 32'h1000); send_pkt(1, 1, 32'h2000); end
        join
        repeat (3) tick();
        expect_pkt(32'h700, 1);
        expect_pkt(32'h1000, 128);
        expect_pkt(32'h710, 1);
        expect_pkt(32'h2000, 1);
        expect_pkt(32'h720, 1);
        expect_pkt(32'h730, 1);
        compare_out("t6_mix");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
